id_issue_coord_t: RTL and testbench
===================================

# id_issue_coord_t

Parametrised N-lane decode-stage issue coordinator for the superscalar core. It generalises the two-lane ID coordination logic: any lane count, a registered rotating oldest-lane pointer instead of per-lane order bits, in-order partial issue, youngest-lane squash on taken branch, and a registered fetch redirect. It sits between the ID lane decoders and the EX/ME lanes, and drives the per-lane stall/issue controls plus the fetch-unit redirect.

## Interface
Parameters:
- LANES, 2, number of issue lanes (2..4); lane i occupies bits [i*W +: W] of packed buses
- XLEN, 32, branch target address width
- RW, 5, register index width
- STALL_CW, 8, width of consecutive-stall counter

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- ACT  in  1  block activation; 0 forces combinational outputs to 0 and freezes all state
- id_valid  in  LANES  lane holds a decoded instruction
- id_rs1, id_rs2, id_rd  in  LANES*RW  lane source/dest registers
- id_regwrite  in  LANES  lane writes id_rd
- id_pcsrc  in  LANES  lane is a taken branch/jump
- id_bradd  in  LANES*XLEN  lane branch target
- ex_load  in  LANES  EX lane holds a load (memop bit 3)
- ex_rd  in  LANES*RW  EX lane destination
- me_load  in  LANES  ME lane holds a load
- me_rd  in  LANES*RW  ME lane destination
- me_memhaz  in  LANES  ME lane load data not yet returned
- ex_stall  in  LANES  EX lane cannot accept
- issue  out  LANES  lane issues this cycle
- stall  out  LANES  lane holds its instruction
- squash  out  LANES  lane's instruction is killed (younger than taken branch)
- head  out  clog2(LANES)  registered index of oldest lane
- redir_valid  out  1  registered fetch redirect
- redir_addr  out  XLEN  registered redirect target
- issue_cnt  out  clog2(LANES)+1  number of lanes issued this cycle
- stall_cnt  out  STALL_CW  registered consecutive full-stall cycles, saturating

## Operation
- Age: lane at age k is (head+k) mod LANES; age 0 oldest.
- Lane hazard haz[i] (valid lane only): any EX lane j with ex_load[j], ex_rd[j]!=0, ex_rd[j] equal to rs1[i] or rs2[i]; or any ME lane j with same match and me_load[j] & me_memhaz[j]; or any older valid lane with regwrite, rd!=0, rd equal to rs1[i]/rs2[i].
- blk[i] = haz[i] | ex_stall[i].
- In-order issue: lane at age k issues iff valid, no blk at ages 0..k, and no older issuing lane has id_pcsrc. stall[i] = valid & ~issue[i] & ~squash[i].
- Branch: oldest issuing lane with id_pcsrc wins; all valid younger lanes get squash=1, issue=0. Squashed and invalid lanes never stall.
- issue_cnt = popcount(issue).
- Registered state on CLK when ACT=1:
  - redir_valid <= any issuing pcsrc; redir_addr <= winner's bradd, else 0.
  - head <= 0 if branch taken, else (head+issue_cnt) mod LANES.
  - stall_cnt <= 0 if issue_cnt!=0 or no valid lane; else min(stall_cnt+1, 2^STALL_CW-1).
- ACT=0: issue/stall/squash/issue_cnt = 0; registers hold.

## Timing
- Reset (RST=0, async): head=0, redir_valid=0, redir_addr=0, stall_cnt=0; issue/stall/squash/issue_cnt follow inputs combinationally (0 when all id_valid=0).
- issue/stall/squash/issue_cnt: combinational, same cycle as inputs.
- redir_*, head, stall_cnt: 1-cycle latency; redir_valid is a 1-cycle pulse per taken branch.
- Head wrap: head+issue_cnt computed modulo LANES (non-power-of-2 LANES included).
- Branch and hazard in same cycle: hazard on older lane blocks the branch lane; no redirect.
- Reset deasserted mid-bundle: first active edge uses head=0.

## Test plan
- LANES=2, head=0, independent ALU ops both lanes -> issue=11, issue_cnt=2, head stays 0 next cycle.
- LANES=4, head=0, lane1 rs1=x5, ex_load[0]=1, ex_rd[0]=5 -> issue=0001, stall=1110, head=1 next cycle.
- LANES=3, head=2, lane0 rs2 = lane2 rd=7 with regwrite -> issue lane2 only, stall lanes 0,1, head=0 next.
- LANES=4, head=0, lane1 pcsrc bradd=0x1000 -> issue=0011, squash=1100, next cycle redir_valid=1, redir_addr=0x1000, head=0; pulse clears following cycle.
- me_memhaz held on x3 used by oldest lane for 300 cycles, STALL_CW=8 -> stall_cnt reaches 255 and saturates; clears to 0 one cycle after issue.
- Assert RST=0 mid-stream with head=2, stall_cnt=5 -> immediately head=0, stall_cnt=0, redir_valid=0; ACT=0 -> issue=0, state frozen.

Source files
------------

// File: rtl/id_issue_coord_t.sv
// N-lane decode-stage issue coordinator: in-order partial issue from a rotating
// oldest-lane pointer, squash of lanes younger than a taken branch, registered fetch redirect.
module id_issue_coord_t #(
    parameter int LANES    = 2,
    parameter int XLEN     = 32,
    parameter int RW       = 5,
    parameter int STALL_CW = 8,
    localparam int HW      = $clog2(LANES)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ACT,
    input  logic [LANES-1:0]      id_valid,
    input  logic [LANES*RW-1:0]   id_rs1,
    input  logic [LANES*RW-1:0]   id_rs2,
    input  logic [LANES*RW-1:0]   id_rd,
    input  logic [LANES-1:0]      id_regwrite,
    input  logic [LANES-1:0]      id_pcsrc,
    input  logic [LANES*XLEN-1:0] id_bradd,
    input  logic [LANES-1:0]      ex_load,
    input  logic [LANES*RW-1:0]   ex_rd,
    input  logic [LANES-1:0]      me_load,
    input  logic [LANES*RW-1:0]   me_rd,
    input  logic [LANES-1:0]      me_memhaz,
    input  logic [LANES-1:0]      ex_stall,
    output logic [LANES-1:0]      issue,
    output logic [LANES-1:0]      stall,
    output logic [LANES-1:0]      squash,
    output logic [HW-1:0]         head,
    output logic                  redir_valid,
    output logic [XLEN-1:0]       redir_addr,
    output logic [HW:0]           issue_cnt,
    output logic [STALL_CW-1:0]   stall_cnt
);

    localparam logic [HW:0] LANES_W = (HW+1)'(LANES);

    logic [LANES-1:0] ext_haz;
    logic [LANES-1:0] issue_c;
    logic [LANES-1:0] squash_c;
    logic [HW:0]      cnt_c;
    logic             br_c;
    logic [XLEN-1:0]  br_addr_c;
    logic [HW:0]      head_sum;
    logic [HW-1:0]    head_nxt;

    function automatic int lane_at(input logic [HW-1:0] h, input int k);
        int l;
        l = int'(h) + k;
        return (l >= LANES) ? l - LANES : l;
    endfunction

    // x0 is never a real dependency, so a zero destination never matches.
    function automatic logic uses(input logic [RW-1:0] r, input logic [RW-1:0] s1,
                                  input logic [RW-1:0] s2);
        return (r != '0) && (r == s1 || r == s2);
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ext_haz = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (ex_load[j] && uses(ex_rd[j*RW +: RW], id_rs1[i*RW +: RW], id_rs2[i*RW +: RW]))
                    ext_haz[i] = id_valid[i];
                if (me_load[j] && me_memhaz[j] &&
                    uses(me_rd[j*RW +: RW], id_rs1[i*RW +: RW], id_rs2[i*RW +: RW]))
                    ext_haz[i] = id_valid[i];
            end
        end
    end

    // Walk lanes oldest-first; the first block stops all younger issue,
    // the first issuing branch turns every younger valid lane into a squash.
    always_comb begin
        int   li;
        int   lo;
        logic haz;
        logic blocked;
        issue_c   = '0;
        squash_c  = '0;
        cnt_c     = '0;
        br_c      = 1'b0;
        br_addr_c = '0;
        blocked   = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            li  = lane_at(head, k);
            haz = ext_haz[li];
            for (int a = 0; a < k; a++) begin
                lo = lane_at(head, a);
                if (id_valid[lo] && id_regwrite[lo] &&
                    uses(id_rd[lo*RW +: RW], id_rs1[li*RW +: RW], id_rs2[li*RW +: RW]))
                    haz = haz | id_valid[li];
            end
            blocked = blocked | haz | ex_stall[li];
            if (id_valid[li]) begin
                if (br_c) begin
                    squash_c[li] = 1'b1;
                end else if (!blocked) begin
                    issue_c[li] = 1'b1;
                    if (id_pcsrc[li]) begin
                        br_c      = 1'b1;
                        br_addr_c = id_bradd[li*XLEN +: XLEN];
                    end
                end
            end
        end
        for (int i = 0; i < LANES; i++)
            cnt_c = cnt_c + {{HW{1'b0}}, issue_c[i]};
    end

    assign issue     = ACT ? issue_c : '0;
    assign squash    = ACT ? squash_c : '0;
    assign stall     = ACT ? (id_valid & ~issue_c & ~squash_c) : '0;
    assign issue_cnt = ACT ? cnt_c : '0;

    // Sum never exceeds 2*LANES-1, so one conditional subtract is a full modulo.
    assign head_sum = {1'b0, head} + cnt_c;
    assign head_nxt = (head_sum >= LANES_W) ? HW'(head_sum - LANES_W) : HW'(head_sum);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head        <= '0;
            redir_valid <= 1'b0;
            redir_addr  <= '0;
            stall_cnt   <= '0;
        end else if (ACT) begin
            redir_valid <= br_c;
            redir_addr  <= br_c ? br_addr_c : '0;
            head        <= br_c ? '0 : head_nxt;
            if (cnt_c != '0 || id_valid == '0)
                stall_cnt <= '0;
            else if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_issue_coord_t.sv
// Bench for id_issue_coord_t: a 4-lane and a 3-lane instance, table vectors,
// directed multi-cycle sequences and randomized traffic against an age-based reference model.
module tb_id_issue_coord_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        regwrite, pcsrc;
        logic [31:0] bradd;
        logic        exl;
        logic [4:0]  exrd;
        logic        mel;
        logic [4:0]  merd;
        logic        memhaz;
        logic        exst;
    } lane_t;

    typedef struct {
        logic [3:0]  issue, stall, squash;
        int          cnt;
        bit          br;
        logic [31:0] addr;
        bit          anyv;
    } res_t;

    typedef struct {
        logic [3:0]  valid, exst, pcsrc;
        int          haz_lane;
        logic [3:0]  e_issue, e_stall, e_squash;
        int          e_head;
        logic        e_rv;
        logic [31:0] e_ra;
    } vec_t;

    logic CLK, RST, ACT;
    lane_t ln [2][4];

    logic [3:0]   v4, rw4, pc4, exl4, mel4, mh4, exs4, iss4, stl4, sq4;
    logic [19:0]  rs1_4, rs2_4, rd4, exrd4, merd4;
    logic [127:0] bra4;
    logic [1:0]   hd4;
    logic         rv4;
    logic [31:0]  ra4;
    logic [2:0]   cnt4;
    logic [7:0]   sc4;

    logic [2:0]   v3, rw3, pc3, exl3, mel3, mh3, exs3, iss3, stl3, sq3;
    logic [14:0]  rs1_3, rs2_3, rd3, exrd3, merd3;
    logic [95:0]  bra3;
    logic [1:0]   hd3;
    logic         rv3;
    logic [31:0]  ra3;
    logic [2:0]   cnt3;
    logic [7:0]   sc3;

    int n_checks = 0;
    int n_errors = 0;
    int m_head [2];
    int m_sc   [2];
    bit m_rv   [2];
    logic [31:0] m_ra [2];

    id_issue_coord_t #(.LANES(4), .XLEN(32), .RW(5), .STALL_CW(8)) dut4 (
        .CLK(CLK), .RST(RST), .ACT(ACT),
        .id_valid(v4), .id_rs1(rs1_4), .id_rs2(rs2_4), .id_rd(rd4),
        .id_regwrite(rw4), .id_pcsrc(pc4), .id_bradd(bra4),
        .ex_load(exl4), .ex_rd(exrd4), .me_load(mel4), .me_rd(merd4),
        .me_memhaz(mh4), .ex_stall(exs4),
        .issue(iss4), .stall(stl4), .squash(sq4), .head(hd4),
        .redir_valid(rv4), .redir_addr(ra4), .issue_cnt(cnt4), .stall_cnt(sc4)
    );

    id_issue_coord_t #(.LANES(3), .XLEN(32), .RW(5), .STALL_CW(8)) dut3 (
        .CLK(CLK), .RST(RST), .ACT(ACT),
        .id_valid(v3), .id_rs1(rs1_3), .id_rs2(rs2_3), .id_rd(rd3),
        .id_regwrite(rw3), .id_pcsrc(pc3), .id_bradd(bra3),
        .ex_load(exl3), .ex_rd(exrd3), .me_load(mel3), .me_rd(merd3),
        .me_memhaz(mh3), .ex_stall(exs3),
        .issue(iss3), .stall(stl3), .squash(sq3), .head(hd3),
        .redir_valid(rv3), .redir_addr(ra3), .issue_cnt(cnt3), .stall_cnt(sc3)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            v4[i] = ln[0][i].valid;    rw4[i] = ln[0][i].regwrite; pc4[i] = ln[0][i].pcsrc;
            exl4[i] = ln[0][i].exl;    mel4[i] = ln[0][i].mel;     mh4[i] = ln[0][i].memhaz;
            exs4[i] = ln[0][i].exst;
            rs1_4[i*5 +: 5] = ln[0][i].rs1;  rs2_4[i*5 +: 5] = ln[0][i].rs2;
            rd4[i*5 +: 5]   = ln[0][i].rd;   exrd4[i*5 +: 5] = ln[0][i].exrd;
            merd4[i*5 +: 5] = ln[0][i].merd; bra4[i*32 +: 32] = ln[0][i].bradd;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            v3[i] = ln[1][i].valid;    rw3[i] = ln[1][i].regwrite; pc3[i] = ln[1][i].pcsrc;
            exl3[i] = ln[1][i].exl;    mel3[i] = ln[1][i].mel;     mh3[i] = ln[1][i].memhaz;
            exs3[i] = ln[1][i].exst;
            rs1_3[i*5 +: 5] = ln[1][i].rs1;  rs2_3[i*5 +: 5] = ln[1][i].rs2;
            rd3[i*5 +: 5]   = ln[1][i].rd;   exrd3[i*5 +: 5] = ln[1][i].exrd;
            merd3[i*5 +: 5] = ln[1][i].merd; bra3[i*32 +: 32] = ln[1][i].bradd;
        end
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                ln[d][i].valid = 1'b0;  ln[d][i].regwrite = 1'b1; ln[d][i].pcsrc = 1'b0;
                ln[d][i].rs1 = 5'(10 + 2*i); ln[d][i].rs2 = 5'(11 + 2*i); ln[d][i].rd = 5'(20 + i);
                ln[d][i].bradd = 32'h800 * (i + 1);
                ln[d][i].exl = 1'b0; ln[d][i].exrd = 5'd0; ln[d][i].mel = 1'b0;
                ln[d][i].merd = 5'd0; ln[d][i].memhaz = 1'b0; ln[d][i].exst = 1'b0;
            end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_head[d] = 0; m_sc[d] = 0; m_rv[d] = 0; m_ra[d] = '0;
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        #1;
        RST = 1'b1;
        model_reset();
    endtask

    function automatic bit reads(int d, int i, logic [4:0] r);
        return r != 0 && (ln[d][i].rs1 == r || ln[d][i].rs2 == r);
    endfunction

    // Reference: find the youngest age reachable before the first blocker,
    // then cut at the oldest branch among those.
    function automatic res_t model(int d);
        res_t r;
        int   n, first_block, br_age;
        int   age [4];
        bit   blk [4];
        bit   h;
        n = (d == 0) ? 4 : 3;
        r.issue = '0; r.stall = '0; r.squash = '0; r.cnt = 0; r.addr = '0; r.anyv = 0;
        for (int i = 0; i < n; i++) age[i] = (i - m_head[d] + n) % n;
        for (int i = 0; i < n; i++) begin
            h = 0;
            if (ln[d][i].valid) begin
                r.anyv = 1;
                for (int j = 0; j < n; j++) begin
                    if (ln[d][j].exl && reads(d, i, ln[d][j].exrd)) h = 1;
                    if (ln[d][j].mel && ln[d][j].memhaz && reads(d, i, ln[d][j].merd)) h = 1;
                    if (age[j] < age[i] && ln[d][j].valid && ln[d][j].regwrite &&
                        reads(d, i, ln[d][j].rd)) h = 1;
                end
            end
            blk[i] = h || ln[d][i].exst;
        end
        first_block = n;
        for (int i = 0; i < n; i++) if (blk[i] && age[i] < first_block) first_block = age[i];
        br_age = n;
        for (int i = 0; i < n; i++)
            if (ln[d][i].valid && ln[d][i].pcsrc && age[i] < first_block && age[i] < br_age) begin
                br_age = age[i];
                r.addr = ln[d][i].bradd;
            end
        r.br = br_age < n;
        for (int i = 0; i < n; i++) begin
            r.issue[i]  = ln[d][i].valid && age[i] < first_block && age[i] <= br_age;
            r.squash[i] = ln[d][i].valid && r.br && age[i] > br_age;
            r.stall[i]  = ln[d][i].valid && !r.issue[i] && !r.squash[i];
            r.cnt += int'(r.issue[i]);
        end
        if (!ACT) begin
            r.issue = '0; r.stall = '0; r.squash = '0; r.cnt = 0;
        end
        return r;
    endfunction

    // One clock against the model: combinational checks before the edge, state after it.
    task automatic cycle();
        res_t r [2];
        int   n;
        #2;
        for (int d = 0; d < 2; d++) begin
            r[d] = model(d);
            check($sformatf("d%0d issue", d),  (d == 0) ? 64'(iss4) : 64'(iss3), 64'(r[d].issue));
            check($sformatf("d%0d stall", d),  (d == 0) ? 64'(stl4) : 64'(stl3), 64'(r[d].stall));
            check($sformatf("d%0d squash", d), (d == 0) ? 64'(sq4)  : 64'(sq3),  64'(r[d].squash));
            check($sformatf("d%0d issue_cnt", d), (d == 0) ? 64'(cnt4) : 64'(cnt3), 64'(r[d].cnt));
        end
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 4 : 3;
            if (ACT) begin
                m_rv[d]   = r[d].br;
                m_ra[d]   = r[d].br ? r[d].addr : '0;
                m_head[d] = r[d].br ? 0 : (m_head[d] + r[d].cnt) % n;
                if (r[d].cnt != 0 || !r[d].anyv) m_sc[d] = 0;
                else if (m_sc[d] < 255) m_sc[d]++;
            end
            check($sformatf("d%0d head", d),        (d == 0) ? 64'(hd4) : 64'(hd3), 64'(m_head[d]));
            check($sformatf("d%0d redir_valid", d), (d == 0) ? 64'(rv4) : 64'(rv3), 64'(m_rv[d]));
            check($sformatf("d%0d redir_addr", d),  (d == 0) ? 64'(ra4) : 64'(ra3), 64'(m_ra[d]));
            check($sformatf("d%0d stall_cnt", d),   (d == 0) ? 64'(sc4) : 64'(sc3), 64'(m_sc[d]));
        end
    endtask

    vec_t tab [9];

    initial begin
        tab[0] = '{4'b1111, 4'b0000, 4'b0000, -1, 4'b1111, 4'b0000, 4'b0000, 0, 1'b0, 32'h0};
        tab[1] = '{4'b1111, 4'b0000, 4'b0000,  1, 4'b0001, 4'b1110, 4'b0000, 1, 1'b0, 32'h0};
        tab[2] = '{4'b1111, 4'b0000, 4'b0010, -1, 4'b0011, 4'b0000, 4'b1100, 0, 1'b1, 32'h1000};
        tab[3] = '{4'b0101, 4'b0000, 4'b0000, -1, 4'b0101, 4'b0000, 4'b0000, 2, 1'b0, 32'h0};
        tab[4] = '{4'b1111, 4'b0001, 4'b0000, -1, 4'b0000, 4'b1111, 4'b0000, 0, 1'b0, 32'h0};
        tab[5] = '{4'b1111, 4'b0100, 4'b1000, -1, 4'b0011, 4'b1100, 4'b0000, 2, 1'b0, 32'h0};
        tab[6] = '{4'b1111, 4'b0000, 4'b0001,  2, 4'b0001, 4'b0000, 4'b1110, 0, 1'b1, 32'h800};
        tab[7] = '{4'b1111, 4'b0000, 4'b0100,  1, 4'b0001, 4'b1110, 4'b0000, 1, 1'b0, 32'h0};
        tab[8] = '{4'b0000, 4'b0000, 4'b0000, -1, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, 32'h0};

        RST = 1'b0;
        ACT = 1'b1;
        idle_all();
        model_reset();
        #2;
        check("reset head", 64'(hd4), 0);
        check("reset redir_valid", 64'(rv4), 0);
        check("reset redir_addr", 64'(ra4), 0);
        check("reset stall_cnt", 64'(sc4), 0);
        check("reset issue idle", 64'(iss4), 0);
        #5;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Table vectors on the 4-lane instance, each from head=0.
        for (int v = 0; v < 9; v++) begin
            pulse_reset();
            idle_all();
            for (int i = 0; i < 4; i++) begin
                ln[0][i].valid = tab[v].valid[i];
                ln[0][i].exst  = tab[v].exst[i];
                ln[0][i].pcsrc = tab[v].pcsrc[i];
            end
            if (tab[v].haz_lane >= 0) begin
                ln[0][tab[v].haz_lane].rs1 = 5'd5;
                ln[0][0].exl  = 1'b1;
                ln[0][0].exrd = 5'd5;
            end
            #2;
            check($sformatf("vec%0d issue", v),  64'(iss4), 64'(tab[v].e_issue));
            check($sformatf("vec%0d stall", v),  64'(stl4), 64'(tab[v].e_stall));
            check($sformatf("vec%0d squash", v), 64'(sq4),  64'(tab[v].e_squash));
            check($sformatf("vec%0d issue_cnt", v), 64'(cnt4), 64'($countones(tab[v].e_issue)));
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d head", v), 64'(hd4), 64'(tab[v].e_head));
            check($sformatf("vec%0d redir_valid", v), 64'(rv4), 64'(tab[v].e_rv));
            check($sformatf("vec%0d redir_addr", v), 64'(ra4), 64'(tab[v].e_ra));
        end

        // Redirect is a single-cycle pulse.
        pulse_reset();
        idle_all();
        for (int i = 0; i < 4; i++) ln[0][i].valid = 1'b1;
        ln[0][1].pcsrc = 1'b1;
        cycle();
        check("branch redir_valid", 64'(rv4), 1);
        check("branch redir_addr", 64'(ra4), 64'h1000);
        idle_all();
        cycle();
        check("pulse cleared", 64'(rv4), 0);

        // 3-lane: wrap head to 2, then an in-bundle dependency across the wrap.
        ln[1][0].valid = 1'b1;
        ln[1][1].valid = 1'b1;
        cycle();
        check("l3 head=2", 64'(hd3), 2);
        for (int i = 0; i < 3; i++) ln[1][i].valid = 1'b1;
        ln[1][0].rs2 = 5'd7;
        ln[1][2].rd  = 5'd7;
        #1;
        check("l3 dep issue", 64'(iss3), 64'(3'b100));
        check("l3 dep stall", 64'(stl3), 64'(3'b011));
        cycle();
        check("l3 head wrap", 64'(hd3), 0);

        // Long memory-hazard stall saturates the counter.
        pulse_reset();
        idle_all();
        ln[0][0].valid  = 1'b1;
        ln[0][0].rs1    = 5'd3;
        ln[0][1].mel    = 1'b1;
        ln[0][1].merd   = 5'd3;
        ln[0][1].memhaz = 1'b1;
        for (int c = 0; c < 300; c++) begin
            cycle();
            if (c == 254) check("stall_cnt at 255", 64'(sc4), 255);
        end
        check("stall_cnt saturated", 64'(sc4), 255);
        ln[0][1].memhaz = 1'b0;
        cycle();
        check("stall_cnt cleared", 64'(sc4), 0);
        check("head after release", 64'(hd4), 1);

        // Mid-stream asynchronous reset.
        pulse_reset();
        idle_all();
        ln[0][0].valid = 1'b1;
        ln[0][1].valid = 1'b1;
        cycle();
        idle_all();
        ln[0][2].valid = 1'b1;
        ln[0][2].exst  = 1'b1;
        repeat (5) cycle();
        check("pre-reset head", 64'(hd4), 2);
        check("pre-reset stall_cnt", 64'(sc4), 5);
        RST = 1'b0;
        #1;
        check("async reset head", 64'(hd4), 0);
        check("async reset stall_cnt", 64'(sc4), 0);
        check("async reset redir_valid", 64'(rv4), 0);
        RST = 1'b1;
        model_reset();

        // ACT=0 gates outputs and freezes state.
        idle_all();
        ln[0][0].valid = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) ln[0][i].valid = 1'b1;
        ln[0][3].pcsrc = 1'b1;
        ACT = 1'b0;
        #1;
        check("inactive issue", 64'(iss4), 0);
        check("inactive stall", 64'(stl4), 0);
        check("inactive issue_cnt", 64'(cnt4), 0);
        cycle();
        check("inactive head frozen", 64'(hd4), 1);
        check("inactive no redirect", 64'(rv4), 0);
        ACT = 1'b1;

        // Randomized traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            ACT = ($urandom_range(0, 7) != 0);
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 4; i++) begin
                    ln[d][i].valid    = ($urandom_range(0, 3) != 0);
                    ln[d][i].rs1      = 5'($urandom_range(0, 3));
                    ln[d][i].rs2      = 5'($urandom_range(0, 3));
                    ln[d][i].rd       = 5'($urandom_range(0, 3));
                    ln[d][i].regwrite = 1'($urandom_range(0, 1));
                    ln[d][i].pcsrc    = ($urandom_range(0, 4) == 0);
                    ln[d][i].bradd    = $urandom;
                    ln[d][i].exl      = ($urandom_range(0, 3) == 0);
                    ln[d][i].exrd     = 5'($urandom_range(0, 3));
                    ln[d][i].mel      = 1'($urandom_range(0, 1));
                    ln[d][i].merd     = 5'($urandom_range(0, 3));
                    ln[d][i].memhaz   = ($urandom_range(0, 2) == 0);
                    ln[d][i].exst     = ($urandom_range(0, 5) == 0);
                end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
